// File: rtl/mbist_march_engine.sv
// SRAM self-test engine: MSCAN, checkerboard and March C- with pipelined compare.
// Define MBIST_FAIL_LOG_EN to capture the first-fail address and syndrome.
module mbist_march_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              START,
  input  logic [1:0]        TESTTYPE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_WE,
  output logic              MEM_RE,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [ADDR_W-1:0] FAIL_ADDR,
  output logic [DATA_W-1:0] FAIL_SYND
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  function automatic logic [DATA_W-1:0] ckb_pat();
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DATA_W; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [DATA_W-1:0] CKB_P = ckb_pat();

  state_t            state_q, state_d;
  logic [1:0]        type_q, type_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ph_q, ph_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              re_q, re_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic              chk_q, chk_d;
  logic [DATA_W-1:0] chk_exp_q, chk_exp_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;

  logic              start_acc, issue;
  logic [1:0]        t;
  logic [2:0]        e, nelem;
  logic [ADDR_W-1:0] c, a;
  logic              p, pair, rd, dn, v0, v1;
  logic              op_rd, op_v;
  logic [DATA_W-1:0] base, val, synd;
  logic              mism;

  always_comb begin
    start_acc = START && TESTTYPE != 2'd3 &&
                (state_q == S_IDLE || state_q == S_DONE);
    t = start_acc ? TESTTYPE : type_q;
    e = start_acc ? 3'd0 : elem_q;
    c = start_acc ? '0 : cnt_q;
    p = start_acc ? 1'b0 : ph_q;

    // MSCAN/checkerboard: w,r,w,r; odd elements read, upper half inverted
    pair  = 1'b0;
    rd    = e[0];
    dn    = 1'b0;
    v0    = e[1];
    v1    = 1'b0;
    nelem = 3'd4;
    if (t == 2'd2) begin
      nelem = 3'd6;
      pair  = (e != 3'd0) && (e != 3'd5);
      rd    = (e != 3'd0);
      dn    = (e >= 3'd3);
      v0    = (e == 3'd2) || (e == 3'd4);
      v1    = ~v0;
    end

    a     = dn ? ~c : c;
    op_rd = pair ? ~p : rd;
    op_v  = (pair && p) ? v1 : v0;
    base  = '0;
    if (t == 2'd1) base = a[0] ? ~CKB_P : CKB_P;
    val   = base ^ {DATA_W{op_v}};

    state_d = state_q;
    type_d  = type_q;
    elem_d  = elem_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    addr_d  = '0;
    wdata_d = '0;
    we_d    = 1'b0;
    re_d    = 1'b0;
    exp_d   = exp_q;
    issue   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_d = S_RUN;
          type_d  = TESTTYPE;
          elem_d  = 3'd0;
          cnt_d   = '0;
          ph_d    = 1'b0;
          issue   = 1'b1;
        end
      end
      S_RUN: begin
        if (elem_q == nelem) state_d = S_DRAIN;
        else issue = 1'b1;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      addr_d  = a;
      we_d    = ~op_rd;
      re_d    = op_rd;
      wdata_d = op_rd ? '0 : val;
      if (op_rd) exp_d = val;
      if (pair && !p) begin
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        if (c == '1) begin
          cnt_d  = '0;
          elem_d = e + 3'd1;
        end else begin
          cnt_d = c + 1'b1;
        end
      end
    end

    chk_d     = re_q;
    chk_exp_d = exp_q;
    synd      = MEM_RDATA ^ chk_exp_q;
    mism      = chk_q && (synd != '0);
    fail_d    = start_acc ? 1'b0 : (fail_q | mism);
    busy_d    = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q   <= S_IDLE;
      type_q    <= '0;
      elem_q    <= '0;
      cnt_q     <= '0;
      ph_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      exp_q     <= '0;
      chk_q     <= 1'b0;
      chk_exp_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      type_q    <= type_d;
      elem_q    <= elem_d;
      cnt_q     <= cnt_d;
      ph_q      <= ph_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      re_q      <= re_d;
      exp_q     <= exp_d;
      chk_q     <= chk_d;
      chk_exp_q <= chk_exp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
    end
  end

  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign MEM_WE    = we_q;
  assign MEM_RE    = re_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign FAIL      = fail_q;

`ifdef MBIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0] fail_synd_q, fail_synd_d;

  always_comb begin
    chk_addr_d  = addr_q;
    fail_addr_d = fail_addr_q;
    fail_synd_d = fail_synd_q;
    if (start_acc) begin
      fail_addr_d = '0;
      fail_synd_d = '0;
    end else if (mism && !fail_q) begin
      fail_addr_d = chk_addr_q;
      fail_synd_d = synd;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      chk_addr_q  <= '0;
      fail_addr_q <= '0;
      fail_synd_q <= '0;
    end else begin
      chk_addr_q  <= chk_addr_d;
      fail_addr_q <= fail_addr_d;
      fail_synd_q <= fail_synd_d;
    end
  end

  assign FAIL_ADDR = fail_addr_q;
  assign FAIL_SYND = fail_synd_q;
`else
  assign FAIL_ADDR = '0;
  assign FAIL_SYND = '0;
`endif

endmodule

// File: tb/tb_mbist_march_engine.sv
// Bench for mbist_march_engine: SRAM with injectable stuck-at-1 bit and
// an op-list reference model built directly from the march definitions.
module tb_mbist_march_engine;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int D  = 16;

  logic          CLK = 1'b0;
  logic          nRESET = 1'b0;
  logic          START = 1'b0;
  logic [1:0]    TESTTYPE = 2'd0;
  logic [AW-1:0] MEM_ADDR, FAIL_ADDR;
  logic [DW-1:0] MEM_WDATA, MEM_RDATA, FAIL_SYND;
  logic          MEM_WE, MEM_RE, BUSY, DONE, FAIL;

  int checks = 0;
  int failures = 0;

  mbist_march_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK(CLK), .nRESET(nRESET), .START(START), .TESTTYPE(TESTTYPE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE),
    .MEM_RE(MEM_RE), .MEM_RDATA(MEM_RDATA), .BUSY(BUSY), .DONE(DONE),
    .FAIL(FAIL), .FAIL_ADDR(FAIL_ADDR), .FAIL_SYND(FAIL_SYND)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] sram [D];
  logic          flt_en = 1'b0;
  logic [AW-1:0] flt_a = '0;
  logic [DW-1:0] flt_m = '0;
  logic [DW-1:0] rdata_r = '0;
  assign MEM_RDATA = rdata_r;

  always @(posedge CLK) begin
    if (MEM_WE) sram[MEM_ADDR] <= MEM_WDATA;
    if (MEM_RE)
      rdata_r <= sram[MEM_ADDR] |
                 ((flt_en && MEM_ADDR == flt_a) ? flt_m : '0);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic          we;
    logic          re;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } op_t;

  op_t           q[$];
  logic [DW-1:0] mm [D];
  bit            mfail;
  int            mj;
  logic [AW-1:0] maddr;
  logic [DW-1:0] msynd;

  function automatic void add(bit rd, int ai, bit v, bit ckb);
    op_t           o;
    logic [DW-1:0] d, rv;
    logic [AW-1:0] a;
    a = AW'(ai);
    d = {DW{v}};
    if (ckb) d = d ^ ((ai % 2 == 1) ? 8'hAA : 8'h55);
    o.we = !rd;
    o.re = rd;
    o.a  = a;
    o.d  = d;
    q.push_back(o);
    if (rd) begin
      rv = mm[a] | ((flt_en && a == flt_a) ? flt_m : '0);
      if (rv != d && !mfail) begin
        mfail = 1'b1;
        mj    = q.size() - 1;
        maddr = a;
        msynd = rv ^ d;
      end
    end else begin
      mm[a] = d;
    end
  endfunction

  function automatic void build(int tt);
    q.delete();
    mfail = 1'b0;
    mj    = 0;
    maddr = '0;
    msynd = '0;
    if (tt < 2) begin
      for (int ph = 0; ph < 4; ph++)
        for (int k = 0; k < D; k++)
          add(ph % 2 == 1, k, ph >= 2, tt == 1);
    end else begin
      for (int k = 0; k < D; k++) add(1'b0, k, 1'b0, 1'b0);
      for (int k = 0; k < D; k++) begin
        add(1'b1, k, 1'b0, 1'b0); add(1'b0, k, 1'b1, 1'b0);
      end
      for (int k = 0; k < D; k++) begin
        add(1'b1, k, 1'b1, 1'b0); add(1'b0, k, 1'b0, 1'b0);
      end
      for (int k = D - 1; k >= 0; k--) begin
        add(1'b1, k, 1'b0, 1'b0); add(1'b0, k, 1'b1, 1'b0);
      end
      for (int k = D - 1; k >= 0; k--) begin
        add(1'b1, k, 1'b1, 1'b0); add(1'b0, k, 1'b0, 1'b0);
      end
      for (int k = D - 1; k >= 0; k--) add(1'b1, k, 1'b0, 1'b0);
    end
  endfunction

  // pk: cycle at which a stray START is pulsed (0 = none)
  // rst_at: cycle at which nRESET is pulsed (0 = none)
  task automatic run_test(input int tt, input int pk, input int rst_at);
    int            n;
    logic [16:0]   got, exp;
    logic [AW-1:0] ea;
    logic [DW-1:0] es;
    build(tt);
    n = q.size();
    START    = 1'b1;
    TESTTYPE = 2'(tt);
    for (int cyc = 1; cyc <= n + 2; cyc++) begin
      @(posedge CLK);
      #1;
      START = 1'b0;
      exp = '0;
      if (cyc <= n)
        exp = {q[cyc-1].we, q[cyc-1].re, q[cyc-1].a,
               q[cyc-1].we ? q[cyc-1].d : 8'h00, 1'b1, 1'b0, 1'b0};
      else if (cyc == n + 1)
        exp[2] = 1'b1;
      else
        exp[1] = 1'b1;
      exp[0] = mfail && cyc >= mj + 3;
      got = {MEM_WE, MEM_RE, (MEM_WE | MEM_RE) ? MEM_ADDR : 4'h0,
             MEM_WE ? MEM_WDATA : 8'h00, BUSY, DONE, FAIL};
      check($sformatf("t%0d_cyc%0d", tt, cyc), 64'(got), 64'(exp));
      if (cyc == rst_at) begin
        nRESET = 1'b0;
        #1;
        check("rst_abort", 64'({MEM_WE, MEM_RE, BUSY, DONE, FAIL}), 64'd0);
        @(negedge CLK);
        nRESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_idle", 64'({MEM_WE, MEM_RE, BUSY, DONE}), 64'd0);
        return;
      end
      if (cyc == pk) begin
        START    = 1'b1;
        TESTTYPE = 2'($urandom_range(0, 3));
      end
    end
`ifdef MBIST_FAIL_LOG_EN
    ea = mfail ? maddr : '0;
    es = mfail ? msynd : '0;
`else
    ea = '0;
    es = '0;
`endif
    check($sformatf("t%0d_fail_addr", tt), 64'(FAIL_ADDR), 64'(ea));
    check($sformatf("t%0d_fail_synd", tt), 64'(FAIL_SYND), 64'(es));
  endtask

  task automatic idle_poke();
    logic [1:0] prev;
    prev     = {DONE, FAIL};
    START    = 1'b1;
    TESTTYPE = 2'd3;
    @(posedge CLK);
    #1;
    START = 1'b0;
    check("tt3_ignored", 64'({MEM_WE, MEM_RE, BUSY, DONE, FAIL}),
          64'({3'b000, prev}));
  endtask

  initial begin
    for (int i = 0; i < D; i++) sram[i] = DW'($urandom);
    #12;
    check("reset_outs",
          64'({MEM_ADDR, MEM_WDATA, MEM_WE, MEM_RE, BUSY, DONE, FAIL,
               FAIL_ADDR, FAIL_SYND}), 64'd0);
    @(negedge CLK);
    nRESET = 1'b1;
    @(posedge CLK);
    #1;
    idle_poke();
    run_test(0, 0, 0);
    run_test(1, $urandom_range(1, 65), 0);
    run_test(2, 0, 0);
    flt_en = 1'b1;
    flt_a  = 4'd5;
    flt_m  = 8'h04;
    run_test(2, $urandom_range(1, 161), 0);
    flt_en = 1'b0;
    idle_poke();
    run_test(0, 0, 31);
    run_test(0, 0, 0);
    for (int it = 0; it < 4; it++) begin
      flt_en = 1'($urandom_range(0, 1));
      flt_a  = AW'($urandom);
      flt_m  = DW'(1) << $urandom_range(0, DW - 1);
      run_test($urandom_range(0, 2), $urandom_range(1, 40), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
